uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Next-generation UART transmitter: a parametrised replacement for the single-byte transmitter.
//  Accepts words through a write strobe into an internal FIFO and serialises them onto TxD.
//  Frame format is configurable: data width, parity, stop bits. Rate comes from the 3-bit baud_select table.
//  Line format stays compatible with the existing receiver when DATA_W=8, PARITY=1, STOP_BITS=1.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency; sets the baud divisors
//  DATA_W     8           data bits per frame, 5..9, sent LSB first
//  DEPTH      8           FIFO entries, power of two, 2..64
//  PARITY     1           0 = none, 1 = even, 2 = odd
//  STOP_BITS  1           1 or 2
// PORTS
//  clk          in   1                  system clock, rising edge
//  reset        in   1                  asynchronous, active-high
//  Tx_EN        in   1                  1 = transmitter may start new frames
//  Tx_WR        in   1                  write strobe, one word per high cycle
//  Tx_DATA      in   DATA_W             word to enqueue, sampled when Tx_WR=1
//  baud_select  in   3                  rate index (see BEHAVIOUR)
//  TxD          out  1                  serial line, idles high
//  Tx_BUSY      out  1                  1 while FIFO non-empty or a frame is in progress
//  Tx_FULL      out  1                  FIFO holds DEPTH words
//  Tx_EMPTY     out  1                  FIFO holds 0 words
//  Tx_COUNT     out  $clog2(DEPTH)+1    current FIFO occupancy
//  Tx_OVF       out  1                  one-cycle pulse: write dropped because FIFO was full
// BEHAVIOUR
//  Reset (async) values: TxD=1, Tx_BUSY=0, Tx_FULL=0, Tx_EMPTY=1, Tx_COUNT=0, Tx_OVF=0.
//   - FSM goes to IDLE; FIFO pointers, baud counter and shift register clear.
//   - Reset mid-frame aborts the frame; TxD returns high immediately.
//  Baud table: baud_select 0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200.
//   - Tick divisor DIV = round(CLK_HZ/(16*baud)); at 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
//   - One bit period = 16*DIV clk cycles, exact; e.g. 432 cycles for baud_select=7 at 50 MHz.
//   - baud_select is latched at frame start; changes mid-frame take effect on the next frame.
//  FIFO:
//   - Tx_WR=1 and not full: write at the clock edge; Tx_COUNT increments.
//   - Tx_WR=1 and full: word dropped, contents unchanged, Tx_OVF=1 for the next cycle.
//   - Pop on the same edge as a write when full: both happen, the write is accepted, Tx_COUNT unchanged.
//   - Pointers wrap modulo DEPTH.
//   - Tx_FULL, Tx_EMPTY and Tx_COUNT are registered and consistent in the same cycle.
//  FSM states:
//   - IDLE: if Tx_EN=1 and FIFO not empty, pop into the shift register, compute parity, reset baud counter, go to START.
//   - START: TxD=0 for 1 bit period.
//   - DATA: DATA_W bit periods, LSB first.
//   - PAR: entered only if PARITY!=0. One bit period. Even parity: total count of 1s in data+parity is even. Odd: that count is odd.
//   - STOP: TxD=1 for STOP_BITS bit periods, then back to IDLE.
//  Back-to-back frames:
//   - From STOP end, if Tx_EN=1 and FIFO non-empty, the next START begins on the following cycle (IDLE for one cycle).
//  Latency: Tx_WR at edge k into an empty FIFO while IDLE with Tx_EN=1 gives TxD=0 after edge k+2.
//  Tx_EN=0:
//   - No new frame starts; a frame in progress completes.
//   - Writes are still accepted.
//   - TxD stays 1 in IDLE.
//  Tx_BUSY = (state!=IDLE) | ~Tx_EMPTY, registered.
// TESTING
//  1. Reset; baud_select=7, Tx_EN=1; write 8'hA5 -> TxD low 2 cycles later.
//     Line shows 0,1,0,1,0,0,1,0,1,0,1; even parity bit = 0; 432 cycles per bit.
//     Tx_BUSY drops after the stop bit.
//  2. Tx_EN=0; write 8 words 8'h01..8'h08 -> Tx_FULL=1, Tx_COUNT=8, TxD stays 1.
//     9th write -> Tx_OVF pulses 1 cycle, Tx_COUNT stays 8.
//     Then set Tx_EN=1 -> 8 frames, back-to-back, in order 01..08.
//  3. PARITY=2, STOP_BITS=2, DATA_W=7; send 7'h7F -> data all 1s, parity bit 0.
//     Two stop bit periods high before the next start bit.
//  4. FIFO full and a pop edge; write on that same edge -> write accepted, no Tx_OVF, Tx_COUNT stays 8.
//  5. Assert reset in the middle of the DATA state -> TxD=1 and Tx_EMPTY=1 in the same cycle.
//     No further frames after reset is released.
//  6. Change baud_select 7->6 mid-frame -> current frame keeps 432-cycle bits.
//     Next frame uses 864-cycle bits (54*16).

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Bus bundle for uart_tx_fifo: write/enable/rate controls toward the
// transmitter, serial line and FIFO status back to the host.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    logic                     Tx_EN;
    logic                     Tx_WR;
    logic [DATA_W-1:0]        Tx_DATA;
    logic [2:0]               baud_select;
    logic                     TxD;
    logic                     Tx_BUSY;
    logic                     Tx_FULL;
    logic                     Tx_EMPTY;
    logic [$clog2(DEPTH):0]   Tx_COUNT;
    logic                     Tx_OVF;

    modport master (
        output Tx_EN, Tx_WR, Tx_DATA, baud_select,
        input  TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_COUNT, Tx_OVF
    );

    modport slave (
        input  Tx_EN, Tx_WR, Tx_DATA, baud_select,
        output TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_COUNT, Tx_OVF
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO. Words are queued through Tx_WR and
// serialised LSB first as start / data / optional parity / stop bits.
// The bit period (16 * baud divisor) is latched when a frame starts.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Nominal baud rate for each rate index.
    function automatic int unsigned baud_rate(input logic [2:0] sel);
        int unsigned r;
        case (sel)
            3'd0:    r = 32'd300;
            3'd1:    r = 32'd1200;
            3'd2:    r = 32'd4800;
            3'd3:    r = 32'd9600;
            3'd4:    r = 32'd19200;
            3'd5:    r = 32'd38400;
            3'd6:    r = 32'd57600;
            default: r = 32'd115200;
        endcase
        return r;
    endfunction

    // One bit period in clk cycles: 16 * round(CLK_HZ / (16 * baud)).
    function automatic int unsigned bit_period(input logic [2:0] sel);
        int unsigned b;
        int unsigned hz;
        b  = baud_rate(sel);
        hz = int'(CLK_HZ);
        return 32'd16 * ((hz + 32'd8 * b) / (32'd16 * b));
    endfunction

    // Parity bit appended after the data: even (1) or odd (2).
    function automatic logic parity_bit(input logic [DATA_W-1:0] d);
        logic p;
        if (PARITY == 2) begin
            p = ~(^d);
        end else begin
            p = ^d;
        end
        return p;
    endfunction

    // Slowest rate gives the largest period, which sizes the counters.
    localparam int PW = $clog2(bit_period(3'd0) + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, ovf_q, busy_q, txd_q;
    logic              ovf_d, busy_d, txd_d;
    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic [PW-1:0]     per_q, per_d, cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic              pop_s, push_s, bit_end_s;

    assign pop_s     = (state_q == S_IDLE) & bus.Tx_EN & ~empty_q;
    assign push_s    = bus.Tx_WR & (~full_q | pop_s);
    assign bit_end_s = (cnt_q == per_q - PW'(1));

    // FIFO occupancy and status flags for the coming cycle.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
        ovf_d = bus.Tx_WR & full_q & ~pop_s;
    end

    // Frame sequencer: bit timing, shifting and state transitions.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        par_d   = par_q;
        per_d   = per_q;
        cnt_d   = cnt_q + PW'(1);
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = {PW{1'b0}};
                bit_d = 4'd0;
                if (pop_s) begin
                    sh_d    = mem_q[rd_ptr_q];
                    par_d   = parity_bit(mem_q[rd_ptr_q]);
                    per_d   = PW'(bit_period(bus.baud_select));
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = {PW{1'b0}};
                    bit_d   = 4'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d = {PW{1'b0}};
                    sh_d  = sh_q >> 1;
                    if (bit_q == 4'(DATA_W - 1)) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PAR: begin
                if (bit_end_s) begin
                    cnt_d   = {PW{1'b0}};
                    bit_d   = 4'd0;
                    state_d = S_STOP;
                end else begin
                    state_d = S_PAR;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d = {PW{1'b0}};
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                cnt_d   = {PW{1'b0}};
                bit_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level driven from the current state, so the line trails the state by one cycle.
    always_comb begin
        case (state_q)
            S_IDLE:  txd_d = 1'b1;
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = sh_q[0];
            S_PAR:   txd_d = par_q;
            S_STOP:  txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) | (count_d != {CW{1'b0}});
    end

    // FIFO storage; contents need no reset because pointers guard them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.Tx_DATA;
        end
    end

    // Control state, FIFO pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            txd_q    <= 1'b1;
            state_q  <= S_IDLE;
            sh_q     <= {DATA_W{1'b0}};
            par_q    <= 1'b0;
            per_q    <= {PW{1'b0}};
            cnt_q    <= {PW{1'b0}};
            bit_q    <= 4'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == {CW{1'b0}});
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
            state_q <= state_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.TxD      = txd_q;
    assign bus.Tx_BUSY  = busy_q;
    assign bus.Tx_FULL  = full_q;
    assign bus.Tx_EMPTY = empty_q;
    assign bus.Tx_COUNT = count_q;
    assign bus.Tx_OVF   = ovf_q;

endmodule
